// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions: control symbols, symbol width and the serializer state type.
package hdmi_pkg;

  localparam int TMDS_W = 10;

  localparam logic [TMDS_W-1:0] CTRL0 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] CTRL1 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] CTRL2 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] CTRL3 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } ser_state_e;

endpackage

// File: rtl/tmds_shift_lane.sv
// One TMDS symbol shift register: parallel load, LSB-first right shift, otherwise cleared.
module tmds_shift_lane
  import hdmi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [TMDS_W-1:0] d,
  output logic              q
);

  logic [TMDS_W-1:0] sr;

  // Anything other than load/shift zeroes the lane so the pin idles low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      sr <= {1'b0, sr[TMDS_W-1:1]};
    end else begin
      sr <= '0;
    end
  end

  assign q = sr[0];

endmodule

// File: rtl/tmds_serializer.sv
// Bit-clock TMDS serializer: per-channel shift lanes, pixel strobe, clock-channel pattern, underrun flag.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | no output activity, waiting for en
//   ST_PRIME | one-cycle first capture of din
//   ST_RUN   | serializing; phase 0..9, recapture at phase 9 if en
module tmds_serializer
  import hdmi_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WORD     = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [CHANNELS*WORD-1:0] din,
  input  logic                     din_valid,
  output logic                     pix_stb,
  output logic [CHANNELS-1:0]      tx_data,
  output logic                     tx_clk,
  output logic                     underrun,
  input  logic                     clr_underrun
);

  ser_state_e state, state_nx;
  logic [3:0] phase, phase_nx;
  logic       capture;
  logic       shift;
  logic       last;

  assign last = (phase == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      phase <= 4'd0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = 4'd0;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nx = ST_PRIME;
      end
      ST_PRIME: begin
        capture  = 1'b1;
        state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (!last) begin
          phase_nx = phase + 4'd1;
        end else if (en) begin
          capture = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Phase 9 without capture falls through to clear, emptying the lanes on exit to IDLE.
  assign shift   = (state == ST_RUN) && !last;
  assign pix_stb = capture;
  assign tx_clk  = (state == ST_RUN) && (phase < 4'd5);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [TMDS_W-1:0] sym;
    assign sym = din_valid ? din[c*WORD +: WORD] : CTRL0;

    tmds_shift_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (capture),
      .shift (shift),
      .d     (sym),
      .q     (tx_data[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (capture && !din_valid) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmds_serializer.sv
// Scoreboard bench for tmds_serializer: a bit-stream queue model predicts every output cycle.
module tb_tmds_serializer;

  localparam int CH = 3;
  localparam int W  = 10;
  localparam logic [W-1:0] C0 = 10'b1101010100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [CH*W-1:0]   din = '0;
  logic              din_valid = 1'b0;
  logic              clr_underrun = 1'b0;
  logic              pix_stb;
  logic [CH-1:0]     tx_data;
  logic              tx_clk;
  logic              underrun;

  always #5 clk = ~clk;

  tmds_serializer #(.CHANNELS(CH), .WORD(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .din          (din),
    .din_valid    (din_valid),
    .pix_stb      (pix_stb),
    .tx_data      (tx_data),
    .tx_clk       (tx_clk),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  typedef struct packed {
    logic          stb;
    logic [CH-1:0] d;
    logic          c;
    logic          u;
  } exp_t;

  exp_t        exp_q[$];
  logic [CH:0] m_stream[$];   // pending output cycles: {clk bit, data bits}
  bit          m_prime = 1'b0;
  bit          m_under = 1'b0;
  int          checks = 0;
  int          errors = 0;
  exp_t        mx;

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit will_stb(input bit e);
    return m_prime || (m_stream.size() == 1 && e);
  endfunction

  // One bit-clock cycle: drive inputs after the edge and push the predicted outputs.
  task automatic tick(input bit e, input logic [CH*W-1:0] d, input bit dv, input bit clr, input bit rst);
    exp_t        x;
    logic [CH:0] cur;
    logic [CH:0] ent;
    logic [W-1:0] c0v;
    bit          stb;
    bit          idle;
    c0v = C0;
    @(posedge clk);
    #1;
    en = e; din = d; din_valid = dv; clr_underrun = clr; rst_n = rst;
    if (!rst) begin
      m_stream.delete();
      m_prime = 1'b0;
      m_under = 1'b0;
      x = '0;
    end else begin
      cur  = (m_stream.size() > 0) ? m_stream[0] : '0;
      stb  = will_stb(e);
      idle = (m_stream.size() == 0) && !m_prime;
      x.stb = stb;
      x.d   = cur[CH-1:0];
      x.c   = cur[CH];
      x.u   = m_under;
      if (m_stream.size() > 0) void'(m_stream.pop_front());
      if (stb) begin
        for (int p = 0; p < W; p++) begin
          ent[CH] = (p < 5);
          for (int c = 0; c < CH; c++) ent[c] = dv ? d[c*W+p] : c0v[p];
          m_stream.push_back(ent);
        end
      end
      if (stb && !dv) m_under = 1'b1;
      else if (clr) m_under = 1'b0;
      m_prime = idle && e;
    end
    exp_q.push_back(x);
  endtask

  task automatic rnd_tick(input bit e, input bit rst);
    tick(e, (CH*W)'({$urandom, $urandom}), 1'($urandom), 1'b0, rst);
  endtask

  // Runs with en=1 until the next strobe cycle, which carries word w.
  task automatic feed(input logic [CH*W-1:0] w, input bit dv, input bit clr);
    bit s;
    for (int n = 0; n < 25; n++) begin
      s = will_stb(1'b1);
      if (s) begin
        tick(1'b1, w, dv, clr, 1'b1);
        break;
      end
      rnd_tick(1'b1, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      chk("pix_stb",  CH'(pix_stb),  CH'(mx.stb));
      chk("tx_data",  tx_data,       mx.d);
      chk("tx_clk",   CH'(tx_clk),   CH'(mx.c));
      chk("underrun", CH'(underrun), CH'(mx.u));
    end
  end

  initial begin
    // reset and idle
    repeat (5) rnd_tick(1'b0, 1'b0);
    repeat (20) rnd_tick(1'b0, 1'b1);

    // basic word, then steady stream of 001..00A
    feed({10'h3FF, 10'h000, 10'h155}, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) feed({W'(k), W'(k), W'(k)}, 1'b1, 1'b0);

    // underrun, then clear colliding with a second underrun, then a real clear
    feed(30'($urandom), 1'b0, 1'b0);
    feed(30'($urandom), 1'b1, 1'b0);
    feed(30'($urandom), 1'b0, 1'b1);
    feed(30'($urandom), 1'b1, 1'b1);
    feed(30'($urandom), 1'b1, 1'b0);

    // graceful stop at phase 3
    for (int n = 0; n < 25 && m_stream.size() != 7; n++) rnd_tick(1'b1, 1'b1);
    repeat (15) rnd_tick(1'b0, 1'b1);

    // reset at phase 6, asynchronous drop, restart
    for (int n = 0; n < 25 && m_stream.size() != 4; n++) rnd_tick(1'b1, 1'b1);
    rnd_tick(1'b1, 1'b0);
    #1;
    chk("async_tx_data", tx_data, '0);
    chk("async_tx_clk", CH'(tx_clk), '0);
    rnd_tick(1'b1, 1'b0);
    repeat (25) rnd_tick(1'b1, 1'b1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      tick(($urandom_range(0, 9) < 8), (CH*W)'({$urandom, $urandom}),
           ($urandom_range(0, 9) < 9), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 99) != 0));
    end
    rnd_tick(1'b0, 1'b1);

    @(negedge clk);
    #1;
    chk("queue_drained", CH'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
